// File: rtl/replica_pkg.sv
// Shared replica types and sizing: opt command word, counter widths, drain depth.
// city_num is derived from city_log, so city_num == 2**city_log + 1 always holds.
package replica_pkg;

  localparam int base_num  = 4;
  localparam int base_log  = 2;
  localparam int city_log  = 5;
  localparam int city_num  = 2**city_log + 1;
  localparam int city_w    = city_log + 1;
  localparam int drain_len = 4;
  localparam int drain_w   = (drain_len > 1) ? $clog2(drain_len) : 1;
  localparam int rm_w      = 32;
  localparam int rx_w      = 8;

  typedef enum logic [1:0] {TWO = 2'd0, OR0 = 2'd1, OR1 = 2'd2, THR = 2'd3} opt_command_t;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} gen_state_t;

  typedef struct packed {
    opt_command_t          com;
    logic [base_log-1:0]   base_id;
    logic [city_w-1:0]     k;
    logic [city_w-1:0]     l;
    logic [rm_w-1:0]       r_metropolis;
    logic [rx_w-1:0]       r_exchange;
  } opt_t;

  typedef struct packed {
    logic [city_w-1:0] k;
    logic [city_w-1:0] l;
  } kl_t;

  localparam opt_t opt_idle = '{com: THR, base_id: '0, k: '0, l: '0,
                                r_metropolis: '0, r_exchange: '0};

  // K and L are 1-based city indices; a collision bumps L so the pair is always distinct.
  function automatic kl_t pick_kl(input logic [city_log-1:0] k_bits,
                                  input logic [city_log-1:0] l_bits);
    kl_t r;
    r.k = city_w'(k_bits) + city_w'(1);
    r.l = city_w'(l_bits) + city_w'(1);
    if (r.l == r.k)
      r.l = (r.k == city_w'(city_num - 1)) ? city_w'(1) : r.k + city_w'(1);
    return r;
  endfunction

endpackage

// File: rtl/xorshift64.sv
// xorshift64 (13,7,17) generator; value is the current word, step advances it once.
// An all-zero seed would lock the generator, so it is replaced by 1.
module xorshift64 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [63:0] seed,
  input  logic        step,
  output logic [63:0] value
);

  logic [63:0] seed_safe;
  logic [63:0] t1, t2, t3;

  assign seed_safe = (seed == 64'd0) ? 64'd1 : seed;
  assign t1 = value ^ (value << 13);
  assign t2 = t1 ^ (t1 >> 7);
  assign t3 = t2 ^ (t2 << 17);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  value <= seed_safe;
    else if (step) value <= t3;
  end

endmodule

// File: rtl/opt_gen.sv
// Opt command generator for the metropolis stage. Macro OPT_GEN_OR_OPT_EN enables or-opt (OR0) commands.
// IDLE: waiting for start | RUN: emitting base sweeps | DRAIN: flushing metropolis with THR
module opt_gen
  import replica_pkg::*;
#(
  parameter int          id   = 0,
  parameter logic [63:0] seed = 64'h0123_4567_89AB_CDEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] n_iter,
  input  logic        opt_run,
  output opt_t        out_opt,
  output logic        busy,
  output logic        done
);

  gen_state_t          state, state_nxt;
  logic [base_log-1:0] base_cnt, base_cnt_nxt;
  logic [15:0]         iter_cnt, iter_cnt_nxt;
  logic [15:0]         n_iter_q, n_iter_q_nxt;
  logic [drain_w-1:0]  drain_cnt, drain_cnt_nxt;
  opt_t                out_nxt;
  logic                busy_nxt, done_nxt;
  logic [63:0]         rnd;
  logic                rng_step;
  logic                last_cmd;
  logic                base_wrap;
  opt_command_t        cmd_com;
  kl_t                 kl;
  logic                unused_rnd;

  xorshift64 u_rng (
    .clk     (clk),
    .reset_n (reset_n),
    .seed    (seed ^ 64'(id)),
    .step    (rng_step),
    .value   (rnd)
  );

  assign kl         = pick_kl(rnd[city_log-1:0], rnd[city_log+15:16]);
  assign base_wrap  = (base_cnt == base_log'(base_num - 1));
  assign last_cmd   = base_wrap && (iter_cnt == n_iter_q - 16'd1);
  assign unused_rnd = ^rnd;

`ifdef OPT_GEN_OR_OPT_EN
  assign cmd_com = rnd[31] ? TWO : OR0;
`else
  assign cmd_com = TWO;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && n_iter != 16'd0)                 state_nxt = RUN;
      RUN:     if (opt_run && last_cmd)                      state_nxt = DRAIN;
      DRAIN:   if (opt_run && drain_cnt == drain_w'(0))      state_nxt = IDLE;
      default:                                               state_nxt = IDLE;
    endcase
  end

  // Start capture and done are the only updates not qualified by opt_run.
  always_comb begin
    out_nxt       = out_opt;
    base_cnt_nxt  = base_cnt;
    iter_cnt_nxt  = iter_cnt;
    n_iter_q_nxt  = n_iter_q;
    drain_cnt_nxt = drain_cnt;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    rng_step      = 1'b0;
    case (state)
      IDLE: begin
        if (opt_run) out_nxt.com = THR;
        if (start) begin
          if (n_iter != 16'd0) begin
            busy_nxt     = 1'b1;
            base_cnt_nxt = '0;
            iter_cnt_nxt = '0;
            n_iter_q_nxt = n_iter;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        if (opt_run) begin
          out_nxt = '{com: cmd_com, base_id: base_cnt, k: kl.k, l: kl.l,
                      r_metropolis: rm_w'(rnd[54:32]), r_exchange: rnd[63 -: rx_w]};
          rng_step = 1'b1;
          if (base_wrap) begin
            base_cnt_nxt = '0;
            iter_cnt_nxt = iter_cnt + 16'd1;
          end else begin
            base_cnt_nxt = base_cnt + base_log'(1);
          end
          if (last_cmd) drain_cnt_nxt = drain_w'(drain_len - 1);
        end
      end
      DRAIN: begin
        if (opt_run) begin
          out_nxt.com = THR;
          if (drain_cnt == drain_w'(0)) begin
            done_nxt = 1'b1;
            busy_nxt = 1'b0;
          end else begin
            drain_cnt_nxt = drain_cnt - drain_w'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_opt   <= opt_idle;
      base_cnt  <= '0;
      iter_cnt  <= '0;
      n_iter_q  <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      out_opt   <= out_nxt;
      base_cnt  <= base_cnt_nxt;
      iter_cnt  <= iter_cnt_nxt;
      n_iter_q  <= n_iter_q_nxt;
      drain_cnt <= drain_cnt_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

endmodule

// File: doc/opt_gen.md
OPT_GEN -- requirements
Module: opt_gen

Interface
REQ-001 SHALL have parameter id, default 0, replica index mixed into seed (seed ^ id).
REQ-002 SHALL have parameter seed, default 64'h0123_4567_89AB_CDEF, xorshift64 initial state.
REQ-003 SHALL have port clk  input  1  single rising-edge clock.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a run.
REQ-006 SHALL have port n_iter  input  16  full base sweeps per run, sampled with start.
REQ-007 SHALL have port opt_run  input  1  global pipeline advance; output updates only when high.
REQ-008 SHALL have port out_opt  output  opt_t  command to metropolis in_opt.
REQ-009 SHALL have port busy  output  1  high from accepted start until done.
REQ-010 SHALL have port done  output  1  single-cycle completion pulse.

Function
REQ-011 SHALL implement states IDLE, RUN, DRAIN; all state and output registers advance only on opt_run, except start capture and done.
REQ-012 SHALL, in IDLE, accept start: n_iter!=0 -> RUN, base_cnt=0, iter_cnt=0, busy=1 next cycle; n_iter==0 -> done pulse next cycle, remain IDLE, busy stays 0.
REQ-013 SHALL ignore start while busy.
REQ-014 SHALL, in RUN on each opt_run, register out_opt with base_id=base_cnt, fields from current RNG word, then step RNG once.
REQ-015 SHALL increment base_cnt, wrapping base_num-1 -> 0 with iter_cnt+1; after base_num-1 of iteration n_iter-1 go to DRAIN.
REQ-016 SHALL derive K = 1 + rnd[city_log-1:0]; L = 1 + rnd[city_log+15:16]; if L==K then L = (K==city_num-1) ? 1 : K+1; K!=L always.
REQ-017 SHALL set com = TWO when rnd[31]=1, else OR0 (or-opt marker; metropolis resolves OR0/OR1 from K<L).
REQ-018 SHALL set r_metropolis = rnd[54:32] zero-extended; r_exchange = rnd[63 -: width of r_exchange].
REQ-019 SHALL emit out_opt.com=THR on every opt_run in IDLE and DRAIN; other fields hold.
REQ-020 SHALL stay in DRAIN for drain_len opt_run cycles, then pulse done one clk later, clear busy, enter IDLE.
REQ-021 SHALL hold all outputs and state unchanged when opt_run is low; RNG does not step.
REQ-022 SHALL use xorshift64 (13,7,17); an all-zero seed^id is replaced by 64'h1.
REQ-023 SHALL make RNG sequence identical across runs without reset only if reset re-applied; RNG continues between runs otherwise.

Reset
REQ-024 SHALL, on reset_n low, asynchronously force state=IDLE, out_opt.com=THR, out_opt.base_id=0, busy=0, done=0, counters=0, RNG=seed^id.
REQ-025 SHALL abort any run on reset mid-RUN/DRAIN without emitting done.

Configuration
REQ-026 SHALL honour macro OPT_GEN_OR_OPT_EN: defined -> REQ-017 as written; undefined -> com always TWO, rnd[31] unused.

Structure
REQ-027 SHALL take opt_t, opt_command_t (TWO, OR0, OR1, THR), base_num, base_log, city_num, city_log from replica_pkg.
REQ-028 SHALL add drain_len (default 4, metropolis pipeline depth) to replica_pkg; package SHALL enforce city_num == 2**city_log + 1.
REQ-029 SHALL instantiate one sub-module xorshift64 (clk, reset_n, seed, step, value).

Verification (base_num=4, city_log=5, city_num=33)
REQ-030 SHALL check reset: reset_n=0 mid-RUN -> out_opt.com=THR, busy=0, no done, same RNG word as power-up.
REQ-031 SHALL check sweep: start, n_iter=2, opt_run=1 -> base_id sequence 0,1,2,3,0,1,2,3, then 4 THR, done one pulse, busy falls.
REQ-032 SHALL check stall: opt_run toggled 1,0,0,1 in RUN -> out_opt and RNG frozen during the 0 cycles, sequence identical to REQ-031.
REQ-033 SHALL check range: 10000 commands -> 1<=K,L<=32, K!=L; forced collision K=L=32 -> L=1.
REQ-034 SHALL check config: OPT_GEN_OR_OPT_EN undefined -> all non-THR com==TWO; defined -> both TWO and OR0 present, never OR1/THR in RUN.
REQ-035 SHALL check edge starts: n_iter=0 -> done next cycle, busy never high; start while busy -> no effect on count.
